// File: rtl/register_writeback.sv
// Integer register file, 32x32, with mem/ALU write-back arbitration.
// Ports: clk, reset_n, alu_/mem_write_{req,addr,data}, src{1,2}_{addr,value}, pend_full/count, overflow.
module register_writeback #(
  parameter int PEND_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_write_req,
  input  logic [4:0]  alu_write_addr,
  input  logic [31:0] alu_write_data,
  input  logic        mem_write_req,
  input  logic [4:0]  mem_write_addr,
  input  logic [31:0] mem_write_data,
  input  logic [4:0]  src1_addr,
  input  logic [4:0]  src2_addr,
  output logic [31:0] src1_value,
  output logic [31:0] src2_value,
  output logic        pend_full,
  output logic [2:0]  pend_count,
  output logic        overflow
);

  localparam int D = PEND_DEPTH;

  logic [31:0] r_rf [32];
  logic [4:0]  r_qa [D];
  logic [31:0] r_qd [D];
  logic [2:0]  r_cnt;
  logic        r_ovf;

  logic        w_mem_v;
  logic        w_alu_v;
  logic        w_direct;
  logic        w_push;
  logic        w_drop;
  logic [D-1:0] w_keep;
  logic [2:0]  w_rank [D];
  logic [2:0]  w_kcnt;
  logic [4:0]  w_na [D];
  logic [31:0] w_nd [D];
  logic [2:0]  w_ncnt;
  logic        w_cm_v;
  logic [4:0]  w_cm_addr;
  logic [31:0] w_cm_data;

  // x0 writes are treated as if never requested
  assign w_mem_v  = mem_write_req && (mem_write_addr != 5'd0);
  assign w_alu_v  = alu_write_req && (alu_write_addr != 5'd0);
  assign w_direct = w_alu_v && !w_mem_v && (r_cnt == 3'd0);
  assign w_push   = w_alu_v && !w_direct;

  // Entries surviving this cycle: mem write kills same-addr
  // entries, otherwise a non-empty queue pops its head.
  always_comb begin
    w_keep = '0;
    for (int i = 0; i < D; i++) begin
      w_keep[i] = (3'(i) < r_cnt);
      if (w_mem_v && (r_qa[i] == mem_write_addr))
        w_keep[i] = 1'b0;
      if (!w_mem_v && (i == 0))
        w_keep[i] = 1'b0;
    end
  end

  // Destination slot of each survivor after compaction
  always_comb begin
    w_kcnt = 3'd0;
    for (int i = 0; i < D; i++) begin
      w_rank[i] = w_kcnt;
      if (w_keep[i])
        w_kcnt = w_kcnt + 3'd1;
    end
  end

  assign w_drop = w_push && (w_kcnt == 3'(D));
  assign w_ncnt = w_kcnt + {2'b00, (w_push && !w_drop)};

  always_comb begin
    for (int j = 0; j < D; j++) begin
      w_na[j] = '0;
      w_nd[j] = '0;
      for (int i = 0; i < D; i++) begin
        if (w_keep[i] && (w_rank[i] == 3'(j))) begin
          w_na[j] = r_qa[i];
          w_nd[j] = r_qd[i];
        end
      end
      if (w_push && !w_drop && (w_kcnt == 3'(j))) begin
        w_na[j] = alu_write_addr;
        w_nd[j] = alu_write_data;
      end
    end
  end

  always_comb begin
    w_cm_v    = 1'b0;
    w_cm_addr = '0;
    w_cm_data = '0;
    unique case (1'b1)
      w_mem_v: begin
        w_cm_v    = 1'b1;
        w_cm_addr = mem_write_addr;
        w_cm_data = mem_write_data;
      end
      (!w_mem_v && (r_cnt != 3'd0)): begin
        w_cm_v    = 1'b1;
        w_cm_addr = r_qa[0];
        w_cm_data = r_qd[0];
      end
      w_direct: begin
        w_cm_v    = 1'b1;
        w_cm_addr = alu_write_addr;
        w_cm_data = alu_write_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= '0;
    end else if (w_cm_v) begin
      r_rf[w_cm_addr] <= w_cm_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < D; i++) begin
        r_qa[i] <= '0;
        r_qd[i] <= '0;
      end
    end else begin
      r_cnt <= w_ncnt;
      if (w_drop)
        r_ovf <= 1'b1;
      for (int i = 0; i < D; i++) begin
        r_qa[i] <= w_na[i];
        r_qd[i] <= w_nd[i];
      end
    end
  end

  // Newest wins: ALU in, mem in, queue young->old, array
  function automatic logic [31:0] rd(input logic [4:0] a);
    logic [31:0] v;
    v = r_rf[a];
    for (int i = 0; i < D; i++)
      if ((3'(i) < r_cnt) && (r_qa[i] == a))
        v = r_qd[i];
    if (w_mem_v && (mem_write_addr == a))
      v = mem_write_data;
    if (w_alu_v && (alu_write_addr == a))
      v = alu_write_data;
    if (a == 5'd0)
      v = '0;
    return v;
  endfunction

  always_comb src1_value = rd(src1_addr);
  always_comb src2_value = rd(src2_addr);

  assign pend_count = r_cnt;
  assign pend_full  = (r_cnt == 3'(D));
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback (PEND_DEPTH=2).
// Drives 1 time unit after posedge, checks 2 units after.
module tb_register_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_write_req;
  logic [4:0]  alu_write_addr;
  logic [31:0] alu_write_data;
  logic        mem_write_req;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic [4:0]  src1_addr;
  logic [4:0]  src2_addr;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic        pend_full;
  logic [2:0]  pend_count;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_writeback #(.PEND_DEPTH(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .alu_write_req(alu_write_req),
    .alu_write_addr(alu_write_addr),
    .alu_write_data(alu_write_data),
    .mem_write_req(mem_write_req),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .src1_addr(src1_addr),
    .src2_addr(src2_addr),
    .src1_value(src1_value),
    .src2_value(src2_value),
    .pend_full(pend_full),
    .pend_count(pend_count),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic mr, input logic [4:0] ma,
                     input logic [31:0] md, input logic ar,
                     input logic [4:0] aa, input logic [31:0] ad,
                     input logic [4:0] s1, input logic [4:0] s2);
    @(posedge clk);
    #1;
    mem_write_req  = mr;
    mem_write_addr = ma;
    mem_write_data = md;
    alu_write_req  = ar;
    alu_write_addr = aa;
    alu_write_data = ad;
    src1_addr      = s1;
    src2_addr      = s2;
    #1;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  initial begin
    reset_n = 1'b0;
    mem_write_req = 0; mem_write_addr = 0; mem_write_data = 0;
    alu_write_req = 0; alu_write_addr = 0; alu_write_data = 0;
    src1_addr = 5'd5; src2_addr = 5'd4;
    #2;
    chk("rst_cnt", 32'(pend_count), 32'd0);
    chk("rst_full", 32'(pend_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd", src1_value, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // direct ALU commit
    drv(0, 0, 0, 1, 5'd5, 32'h11111111, 5'd5, 5'd0);
    chk("alu_byp", src1_value, 32'h11111111);
    chk("alu_cnt0", 32'(pend_count), 32'd0);
    idle(5'd5, 5'd0);
    chk("alu_arr", src1_value, 32'h11111111);
    chk("alu_cnt1", 32'(pend_count), 32'd0);

    // collision
    drv(1, 5'd3, 32'hAAAA0000, 1, 5'd4, 32'h00005555, 5'd3, 5'd4);
    chk("col_s1", src1_value, 32'hAAAA0000);
    chk("col_s2", src2_value, 32'h00005555);
    idle(5'd3, 5'd4);
    chk("col_cnt1", 32'(pend_count), 32'd1);
    chk("col_q", src2_value, 32'h00005555);
    idle(5'd3, 5'd4);
    chk("col_cnt0", 32'(pend_count), 32'd0);
    chk("col_x4", src2_value, 32'h00005555);
    chk("col_x3", src1_value, 32'hAAAA0000);

    // invalidation of queued x7
    drv(1, 5'd6, 32'h66, 1, 5'd7, 32'h1, 5'd7, 5'd6);
    chk("inv_q1", src1_value, 32'h1);
    drv(1, 5'd7, 32'h2, 0, 0, 0, 5'd7, 5'd6);
    chk("inv_cnt", 32'(pend_count), 32'd1);
    chk("inv_byp", src1_value, 32'h2);
    idle(5'd7, 5'd6);
    chk("inv_cnt0", 32'(pend_count), 32'd0);
    chk("inv_x7a", src1_value, 32'h2);
    idle(5'd7, 5'd6);
    chk("inv_x7b", src1_value, 32'h2);
    chk("inv_x6", src2_value, 32'h66);

    // same-addr mem+ALU: ALU is younger
    drv(1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 5'd9, 5'd0);
    chk("same_byp", src1_value, 32'hB);
    idle(5'd9, 5'd0);
    chk("same_cnt", 32'(pend_count), 32'd1);
    chk("same_q", src1_value, 32'hB);
    idle(5'd9, 5'd0);
    chk("same_cnt0", 32'(pend_count), 32'd0);
    chk("same_arr", src1_value, 32'hB);

    // x0 writes ignored
    drv(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("x0_byp", src1_value, 32'd0);
    idle(5'd0, 5'd0);
    chk("x0_cnt", 32'(pend_count), 32'd0);
    chk("x0_arr", src1_value, 32'd0);

    // overflow
    drv(1, 5'd10, 32'h1, 1, 5'd11, 32'h2, 5'd15, 5'd14);
    drv(1, 5'd12, 32'h3, 1, 5'd13, 32'h4, 5'd15, 5'd14);
    chk("ov_cnt1", 32'(pend_count), 32'd1);
    chk("ov_full0", 32'(pend_full), 32'd0);
    drv(1, 5'd14, 32'h5, 1, 5'd15, 32'h6, 5'd15, 5'd14);
    chk("ov_cnt2", 32'(pend_count), 32'd2);
    chk("ov_full1", 32'(pend_full), 32'd1);
    chk("ov_pre", 32'(overflow), 32'd0);
    idle(5'd15, 5'd14);
    chk("ov_set", 32'(overflow), 32'd1);
    chk("ov_cnt", 32'(pend_count), 32'd2);
    chk("ov_drop", src1_value, 32'd0);
    chk("ov_mem", src2_value, 32'h5);
    idle(5'd11, 5'd13);
    idle(5'd11, 5'd13);
    chk("ov_drain", 32'(pend_count), 32'd0);
    chk("ov_x11", src1_value, 32'h2);
    chk("ov_x13", src2_value, 32'h4);
    chk("ov_sticky", 32'(overflow), 32'd1);

    // async reset with 2 queued entries
    drv(1, 5'd20, 32'h1, 1, 5'd21, 32'h2, 5'd21, 5'd5);
    drv(1, 5'd22, 32'h3, 1, 5'd23, 32'h4, 5'd21, 5'd5);
    idle(5'd21, 5'd5);
    chk("ar_pre", 32'(pend_count), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("ar_cnt", 32'(pend_count), 32'd0);
    chk("ar_q", src1_value, 32'd0);
    chk("ar_arr", src2_value, 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // invalidation frees a slot for the same-cycle push
    drv(1, 5'd26, 32'h1, 1, 5'd24, 32'h24, 5'd24, 5'd28);
    drv(1, 5'd27, 32'h2, 1, 5'd25, 32'h25, 5'd24, 5'd28);
    drv(1, 5'd24, 32'h99, 1, 5'd28, 32'h28, 5'd24, 5'd28);
    chk("fr_cnt", 32'(pend_count), 32'd2);
    chk("fr_byp", src1_value, 32'h99);
    idle(5'd24, 5'd28);
    chk("fr_cnt2", 32'(pend_count), 32'd2);
    chk("fr_ovf", 32'(overflow), 32'd0);
    chk("fr_x24", src1_value, 32'h99);
    chk("fr_x28", src2_value, 32'h28);
    idle(5'd25, 5'd28);
    idle(5'd25, 5'd28);
    chk("fr_drain", 32'(pend_count), 32'd0);
    chk("fr_x25", src1_value, 32'h25);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
